cpu_seq_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the ArmCore CPU. Owns the PC and steps each

---
 rtl/cpu_seq_ctrl_pkg.sv | 35 +++
 rtl/cpu_bus_watchdog.sv | 40 ++++
 rtl/cpu_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl_pkg
//   Shared definitions for the ArmCore multi-cycle control sequencer:
//   FSM state encodings (also visible on the debug `state` port), the
//   instruction size used for sequential PC advance, and the latched
//   decode-flag bundle carried from DECODE into EXEC/MEM/WB.
// ---------------------------------------------------------------------------
package cpu_seq_ctrl_pkg;

    localparam int INSTR_BYTES = 4;

    // Encodings are fixed: other blocks and debug tooling decode `state`.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // HLT is consumed in DECODE and never needs to be carried forward.
    typedef struct packed {
        logic load;
        logic store;
        logic branch;
    } dec_flags_t;

    // Instruction needs a data-memory phase.
    function automatic logic uses_mem(input dec_flags_t d);
        return d.load | d.store;
    endfunction

endpackage

// File: rtl/cpu_bus_watchdog.sv
// ---------------------------------------------------------------------------
// cpu_bus_watchdog
//   Counts cycles a memory request has waited without an acknowledge and
//   flags expiry on the last permitted wait cycle.
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   clr     in   restart the wait count (no request outstanding)
//   en      in   a request is outstanding and not acknowledged this cycle
//   expire  out  this is wait cycle TIMEOUT-1 and still no acknowledge
// ---------------------------------------------------------------------------
module cpu_bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // `en` already excludes the ack cycle, so an ack on the last cycle wins.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl
//   Multi-cycle control sequencer for the ArmCore CPU. Owns the PC and steps
//   each instruction through FETCH/DECODE/EXEC/(MEM)/WB over a single shared
//   memory port with a req/ack handshake. Drives datapath strobes, keeps
//   cycle and retired-instruction counters, and raises sticky halted/fault.
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   mem_req/we/addr       memory request, held stable until the ack cycle
//   mem_ack               one-cycle completion, ignored without mem_req
//   dec_load/store/branch/halt  decoder outputs, sampled in DECODE
//   br_taken/br_target/data_addr  datapath results, sampled in EXEC
//   ir_load               IR capture pulse (during DECODE)
//   alu_en                ALU strobe (during EXEC)
//   rf_we                 register-file write (during WB)
//   pc                    current PC
//   state                 FSM state (debug)
//   halted, fault         sticky halt, sticky bus-timeout fault
//   cycle_cnt, instret    free-running wrap-around counters
// ---------------------------------------------------------------------------
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [PC_W-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic [PC_W-1:0]  data_addr,
    output logic             ir_load,
    output logic             alu_en,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t          st;
    dec_flags_t      dec_q;
    logic            taken_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] npc;
    logic            wd_expire;

    assign state = st;

    // Branch targets are forced word aligned; sequential advance wraps.
    assign npc = taken_q ? (target_q & ~PC_W'(3))
                         : pc + PC_W'(INSTR_BYTES);

    // mem_req is low in every cycle before FETCH/MEM, so the count is always
    // zero on entry to either request state.
    cpu_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (!mem_req),
        .en     (mem_req && !mem_ack),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_IDLE;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            ir_load   <= 1'b0;
            alu_en    <= 1'b0;
            rf_we     <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            cycle_cnt <= '0;
            instret   <= '0;
            dec_q     <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            // Strobes are single-cycle; states below re-assert as needed.
            ir_load   <= 1'b0;
            alu_en    <= 1'b0;
            rf_we     <= 1'b0;

            case (st)
                S_IDLE: begin
                    st       <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end

                S_FETCH: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir_load <= 1'b1;
                        st      <= S_DECODE;
                    end else if (wd_expire) begin
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                        halted  <= 1'b1;
                        st      <= S_HALT;
                    end
                end

                S_DECODE: begin
                    dec_q.load   <= dec_load;
                    dec_q.store  <= dec_store;
                    dec_q.branch <= dec_branch;
                    if (dec_halt) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        alu_en <= 1'b1;
                        st     <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    taken_q  <= br_taken;
                    target_q <= br_target;
                    if (uses_mem(dec_q)) begin
                        // data_addr is latched straight into the bus address.
                        mem_req  <= 1'b1;
                        mem_we   <= dec_q.store;
                        mem_addr <= data_addr;
                        st       <= S_MEM;
                    end else begin
                        rf_we <= !dec_q.branch;
                        st    <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        rf_we   <= dec_q.load;
                        st      <= S_WB;
                    end else if (wd_expire) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        fault   <= 1'b1;
                        halted  <= 1'b1;
                        st      <= S_HALT;
                    end
                end

                S_WB: begin
                    pc       <= npc;
                    instret  <= instret + 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= npc;
                    st       <= S_FETCH;
                end

                S_HALT: begin
                    halted  <= 1'b1;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end

                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    st      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_seq_ctrl
//   Scoreboard bench: every instruction pushes the bus requests it should
//   cause; each new DUT request pops and compares. Strobes, PC, counters and
//   latency are checked against a small bench-side model.
// ---------------------------------------------------------------------------
module tb_cpu_seq_ctrl;

    localparam int PC_W    = 64;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;
    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_req, mem_we, mem_ack;
    logic [PC_W-1:0]  mem_addr;
    logic             dec_load, dec_store, dec_branch, dec_halt;
    logic             br_taken;
    logic [PC_W-1:0]  br_target, data_addr;
    logic             ir_load, alu_en, rf_we;
    logic [PC_W-1:0]  pc;
    logic [2:0]       state;
    logic             halted, fault;
    logic [CNT_W-1:0] cycle_cnt, instret;

    cpu_seq_ctrl #(
        .PC_W(PC_W), .RESET_PC('0), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .dec_load(dec_load), .dec_store(dec_store), .dec_branch(dec_branch),
        .dec_halt(dec_halt), .br_taken(br_taken), .br_target(br_target),
        .data_addr(data_addr), .ir_load(ir_load), .alu_en(alu_en), .rf_we(rf_we),
        .pc(pc), .state(state), .halted(halted), .fault(fault),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [PC_W-1:0] addr;
    } bus_t;

    bus_t            exp_q[$];
    int              n_chk = 0, n_err = 0;
    int              cyc = 0, cyc_rel = 0;
    int              n_ir = 0, n_alu = 0, n_rf = 0;
    logic [PC_W-1:0] pc_m;
    int              instret_m;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ir_load) n_ir  <= n_ir + 1;
        if (alu_en)  n_alu <= n_alu + 1;
        if (rf_we)   n_rf  <= n_rf + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_inputs();
        mem_ack = 0; dec_load = 0; dec_store = 0; dec_branch = 0; dec_halt = 0;
        br_taken = 0; br_target = '0; data_addr = '0;
    endtask

    // Called on the first cycle of a new request: pop and compare.
    task automatic sb_check(input string tag);
        bus_t e;
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, mem_addr, e.addr);
            chk({tag, "_we"}, mem_we, e.we);
        end
    endtask

    // Waits for a request, checks it, holds ack off `waits` cycles, then acks.
    task automatic bus_xact(input string tag, input int waits, output int t0);
        int k;
        logic [PC_W-1:0] a0;
        logic            w0;
        k = 0;
        while (!mem_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        t0 = cyc;
        sb_check(tag);
        a0 = mem_addr;
        w0 = mem_we;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk({tag, "_hold_req"}, mem_req, 1);
            chk({tag, "_hold_addr"}, mem_addr, a0);
            chk({tag, "_hold_we"}, mem_we, w0);
        end
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk({tag, "_req_drop"}, mem_req, 0);
    endtask

    task automatic do_reset();
        reset = 0;
        clr_inputs();
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instret", instret, 0);
        chk("rst_strobes", {ir_load, alu_en, rf_we}, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1;
        @(negedge clk);
        chk("idle_state", state, 0);
        chk("idle_req", mem_req, 0);
        cyc_rel   = cyc;
        pc_m      = '0;
        instret_m = 0;
    endtask

    task automatic run_instr(input string nm, input int k, input int wf, input int wm,
                             input logic tk, input logic [63:0] tgt,
                             input logic [63:0] da, input logic stray);
        int t0, tx, ir0, alu0, rf0, lat;
        logic [63:0] npc;
        logic        mem;
        mem = (k == K_LD) || (k == K_ST);
        exp_q.push_back('{we: 1'b0, addr: pc_m});
        if (mem) exp_q.push_back('{we: (k == K_ST), addr: da});
        ir0 = n_ir; alu0 = n_alu; rf0 = n_rf;

        bus_xact({nm, "_fetch"}, wf, t0);
        chk({nm, "_ir_load"}, ir_load, 1);
        chk({nm, "_st_decode"}, state, 2);
        dec_load   = (k == K_LD);
        dec_store  = (k == K_ST);
        dec_branch = (k == K_BR);
        @(negedge clk);
        dec_load = 0; dec_store = 0; dec_branch = 0;

        chk({nm, "_alu_en"}, alu_en, 1);
        chk({nm, "_st_exec"}, state, 3);
        br_taken  = tk;
        br_target = tgt;
        data_addr = da;
        mem_ack   = stray;
        @(negedge clk);
        br_taken = 0; mem_ack = 0;

        if (mem) bus_xact({nm, "_mem"}, wm, tx);
        chk({nm, "_st_wb"}, state, 5);
        chk({nm, "_rf_we"}, rf_we, (k == K_ALU) || (k == K_LD));
        npc = tk ? {tgt[63:2], 2'b00} : pc_m + 64'd4;
        instret_m++;
        @(negedge clk);
        pc_m = npc;
        lat  = 4 + wf + (mem ? 1 + wm : 0);

        chk({nm, "_pc"}, pc, pc_m);
        chk({nm, "_instret"}, instret, instret_m);
        chk({nm, "_latency"}, cyc - t0, lat);
        chk({nm, "_st_fetch"}, state, 1);
        chk({nm, "_n_ir"}, n_ir - ir0, 1);
        chk({nm, "_n_alu"}, n_alu - alu0, 1);
        chk({nm, "_n_rf"}, n_rf - rf0, ((k == K_ALU) || (k == K_LD)) ? 1 : 0);
        chk({nm, "_cycle_cnt"}, cycle_cnt, cyc - cyc_rel);
    endtask

    task automatic run_halt();
        int t0, c0;
        exp_q.push_back('{we: 1'b0, addr: pc_m});
        bus_xact("hlt_fetch", 0, t0);
        dec_halt = 1;
        @(negedge clk);
        dec_halt = 0;
        chk("hlt_halted", halted, 1);
        chk("hlt_state", state, 6);
        chk("hlt_req", mem_req, 0);
        chk("hlt_alu_en", alu_en, 0);
        c0 = int'(cycle_cnt);
        repeat (5) @(negedge clk);
        chk("hlt_pc", pc, pc_m);
        chk("hlt_cycle_cnt", cycle_cnt, c0 + 5);
        chk("hlt_still", halted, 1);
        chk("hlt_instret", instret, instret_m);
        chk("hlt_req_after", mem_req, 0);
        chk("hlt_no_fault", fault, 0);
    endtask

    task automatic run_timeout();
        int n;
        exp_q.push_back('{we: 1'b0, addr: pc_m});
        n = 0;
        while (!mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        sb_check("to_fetch");
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_fault", fault, 1);
        chk("to_halted", halted, 1);
        chk("to_state", state, 6);
        repeat (10) @(negedge clk);
        chk("to_fault_sticky", fault, 1);
        chk("to_halted_sticky", halted, 1);
        chk("to_req_off", mem_req, 0);
        chk("to_pc", pc, pc_m);
    endtask

    initial begin
        int t;
        reset = 1;
        clr_inputs();
        #1;
        do_reset();

        run_instr("alu",      K_ALU, 0, 0, 1'b0, 64'h0,   64'h0,   1'b1);
        run_instr("br_tk",    K_BR,  0, 0, 1'b1, 64'h103, 64'h0,   1'b0);
        run_instr("ld",       K_LD,  0, 3, 1'b0, 64'h0,   64'h80,  1'b0);
        run_instr("st",       K_ST,  2, 1, 1'b0, 64'h0,   64'h1F0, 1'b0);
        run_instr("br_nt",    K_BR,  1, 0, 1'b0, 64'h500, 64'h0,   1'b0);
        run_instr("br_top",   K_BR,  0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        run_instr("alu_wrap", K_ALU, 0, 0, 1'b0, 64'h0,   64'h0,   1'b0);

        // Reset while a load is waiting in MEM.
        exp_q.push_back('{we: 1'b0, addr: pc_m});
        exp_q.push_back('{we: 1'b0, addr: 64'h40});
        bus_xact("mid_fetch", 0, t);
        dec_load = 1;
        @(negedge clk);
        dec_load  = 0;
        data_addr = 64'h40;
        @(negedge clk);
        sb_check("mid_mem");
        @(negedge clk);
        do_reset();

        run_instr("alu_a", K_ALU, 0, 0, 1'b0, 64'h0, 64'h0, 1'b0);
        run_instr("alu_b", K_ALU, 0, 0, 1'b0, 64'h0, 64'h0, 1'b0);
        run_halt();

        do_reset();
        run_timeout();

        do_reset();
        run_instr("last_ack", K_ALU, TIMEOUT - 1, 0, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("last_ack_no_fault", fault, 0);
        chk("last_ack_not_halted", halted, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
